// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared types for the hazard_ctrl_pipe scoreboard: in-flight entry layout and select width.
package hazard_ctrl_pipe_pkg;

  // Entries carry the widest legal register address; narrower configurations zero-extend.
  localparam int unsigned HzRegAwMax = 8;

  typedef struct packed {
    logic                  valid;
    logic [HzRegAwMax-1:0] rd;
    logic                  wen;
    logic                  is_load;
    logic                  is_ctrl;
  } hz_entry_t;

  function automatic int unsigned fwd_sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_match.sv
// Priority encoder: finds the youngest in-flight producer of one source register.
module hazard_ctrl_pipe_match
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned SelW = fwd_sel_w(DEPTH)
) (
  input  hz_entry_t [DEPTH-1:0] stage_i,
  input  logic [HzRegAwMax-1:0] src_addr_i,
  input  logic                  src_used_i,
  output logic [SelW-1:0]       sel_o
);

  // Scan oldest to youngest so the smallest matching stage index is kept.
  always_comb begin
    sel_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_used_i && (src_addr_i != '0) && stage_i[k].valid && stage_i[k].wen &&
          (stage_i[k].rd == src_addr_i)) begin
        sel_o = SelW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// In-flight scoreboard deriving decode stall, bubbles, flush handling and writeback info.
// Operand forwarding (load-use stall only) is enabled by defining TAMARISC_FORWARDING_EN.
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CTRL_SHADOW = 3,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned SelW       = fwd_sel_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              d_valid_i,
  input  logic [REG_AW-1:0] d_rs1_addr_i,
  input  logic              d_rs1_used_i,
  input  logic [REG_AW-1:0] d_rs2_addr_i,
  input  logic              d_rs2_used_i,
  input  logic [REG_AW-1:0] d_rd_addr_i,
  input  logic              d_rd_wen_i,
  input  logic              d_is_load_i,
  input  logic              d_is_ctrl_i,
  input  logic              flush_i,
  output logic              issue_o,
  output logic              stall_o,
  output logic [SelW-1:0]   fwd1_sel_o,
  output logic [SelW-1:0]   fwd2_sel_o,
  output logic [REG_AW-1:0] w_rd_addr_o,
  output logic              w_rd_wen_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  hz_entry_t [DEPTH-1:0] stage_q;
  hz_entry_t             d_entry;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [SelW-1:0]       sel1, sel2;
  logic                  data_haz, ctrl_haz;

  assign d_entry = '{valid:   1'b1,
                     rd:      HzRegAwMax'(d_rd_addr_i),
                     wen:     d_rd_wen_i,
                     is_load: d_is_load_i,
                     is_ctrl: d_is_ctrl_i};

  hazard_ctrl_pipe_match #(
    .DEPTH (DEPTH)
  ) u_match_rs1 (
    .stage_i    (stage_q),
    .src_addr_i (HzRegAwMax'(d_rs1_addr_i)),
    .src_used_i (d_rs1_used_i),
    .sel_o      (sel1)
  );

  hazard_ctrl_pipe_match #(
    .DEPTH (DEPTH)
  ) u_match_rs2 (
    .stage_i    (stage_q),
    .src_addr_i (HzRegAwMax'(d_rs2_addr_i)),
    .src_used_i (d_rs2_used_i),
    .sel_o      (sel2)
  );

`ifdef TAMARISC_FORWARDING_EN
  // Only a load still in X cannot be forwarded; everything else bypasses.
  assign data_haz   = stage_q[0].is_load &&
                      ((sel1 == SelW'(1)) || (sel2 == SelW'(1)));
  assign fwd1_sel_o = sel1;
  assign fwd2_sel_o = sel2;
`else
  assign data_haz   = (sel1 != '0) || (sel2 != '0);
  assign fwd1_sel_o = '0;
  assign fwd2_sel_o = '0;
`endif

  always_comb begin
    ctrl_haz = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < CTRL_SHADOW) && stage_q[k].valid && stage_q[k].is_ctrl) begin
        ctrl_haz = d_is_ctrl_i;
      end
    end
  end

  // rst_n_i gating keeps the combinational outputs quiet while reset is held.
  assign stall_o = rst_n_i && d_valid_i && !flush_i && (data_haz || ctrl_haz);
  assign issue_o = rst_n_i && d_valid_i && !flush_i && !stall_o;

  assign w_rd_wen_o  = stage_q[DEPTH-1].valid && stage_q[DEPTH-1].wen;
  assign w_rd_addr_o = w_rd_wen_o ? stage_q[DEPTH-1].rd[REG_AW-1:0] : '0;
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      stage_q[0] <= issue_o ? d_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      if (stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed self-checking bench for hazard_ctrl_pipe (DEPTH=3, CTRL_SHADOW=3, CNT_W=8).
module tb_hazard_ctrl_pipe;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned SelW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            d_valid, rs1_used, rs2_used, rd_wen, is_load, is_ctrl, flush;
  logic [4:0]      rs1, rs2, rd;
  logic            issue, stall, w_wen;
  logic [SelW-1:0] fwd1, fwd2;
  logic [4:0]      w_addr;
  logic [7:0]      cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_pipe #(
    .DEPTH       (DEPTH),
    .REG_AW      (5),
    .CTRL_SHADOW (3),
    .CNT_W       (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .d_valid_i    (d_valid),
    .d_rs1_addr_i (rs1),
    .d_rs1_used_i (rs1_used),
    .d_rs2_addr_i (rs2),
    .d_rs2_used_i (rs2_used),
    .d_rd_addr_i  (rd),
    .d_rd_wen_i   (rd_wen),
    .d_is_load_i  (is_load),
    .d_is_ctrl_i  (is_ctrl),
    .flush_i      (flush),
    .issue_o      (issue),
    .stall_o      (stall),
    .fwd1_sel_o   (fwd1),
    .fwd2_sel_o   (fwd2),
    .w_rd_addr_o  (w_addr),
    .w_rd_wen_o   (w_wen),
    .stall_cnt_o  (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ins(input logic v, input logic [4:0] a1, input logic u1, input logic [4:0] a2,
                     input logic u2, input logic [4:0] d, input logic w, input logic ld,
                     input logic ct);
    d_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; rd_wen = w; is_load = ld; is_ctrl = ct; flush = 1'b0;
  endtask

  task automatic nop();
    ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with a valid instruction at D, then latency to W
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wen", w_wen, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_fwd1", fwd1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_issue", issue, 1);
    tick();
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_nowen_issue", issue, 1);
    tick();
    nop();
    @(negedge clk);
    chk("t1_w_early", w_wen, 0);
    tick();
    @(negedge clk);
    chk("t1_w_wen", w_wen, 1);
    chk("t1_w_addr", w_addr, 5);
    tick();
    @(negedge clk);
    chk("t1_nowen_wen", w_wen, 0);
    chk("t1_nowen_addr", w_addr, 0);
    tick();

    // 2: ADD x5 then ADD x6,x5,x1
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_prod_issue", issue, 1);
    tick();
    ins(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef TAMARISC_FORWARDING_EN
    @(negedge clk);
    chk("t2_stall", stall, 0);
    chk("t2_fwd1", fwd1, 1);
    chk("t2_fwd2", fwd2, 0);
    tick();
    // 3: one unrelated instruction between producer and consumer
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    ins(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_fwd1", fwd1, 2);
    chk("t3_stall", stall, 0);
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall", stall, 1);
      chk("t2_noissue", issue, 0);
      tick();
    end
    @(negedge clk);
    chk("t2_issue", issue, 1);
    chk("t2_cnt", cnt, 3);
    chk("t2_fwd1", fwd1, 0);
    tick();
`endif
    nop();
    repeat (3) tick();

    // 4: load x7 then consumer of x7; x0 never matches
    ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    ins(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
`ifdef TAMARISC_FORWARDING_EN
    @(negedge clk);
    chk("t4_lu_stall", stall, 1);
    tick();
    @(negedge clk);
    chk("t4_issue", issue, 1);
    chk("t4_fwd1", fwd1, 2);
    chk("t4_cnt", cnt, 1);
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_lu_stall", stall, 1);
      tick();
    end
    @(negedge clk);
    chk("t4_issue", issue, 1);
    chk("t4_cnt", cnt, 6);
    tick();
`endif
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_x0_stall", stall, 0);
    chk("t4_x0_issue", issue, 1);
    chk("t4_x0_fwd1", fwd1, 0);
    tick();
    nop();
    repeat (3) tick();

    // 5: flush while D is stalled
    ins(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    ins(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_pre_stall", stall, 1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("t5_fl_stall", stall, 0);
    chk("t5_fl_issue", issue, 0);
    tick();
    nop();
    @(negedge clk);
    chk("t5_w_wen", w_wen, 1);
    chk("t5_w_addr", w_addr, 7);
    tick();
    @(negedge clk);
    chk("t5_bub1", w_wen, 0);
    tick();
    @(negedge clk);
    chk("t5_bub2", w_wen, 0);
`ifdef TAMARISC_FORWARDING_EN
    chk("t5_cnt", cnt, 2);
`else
    chk("t5_cnt", cnt, 7);
`endif
    tick();

    // 6: branch at D while JAL in stage 1
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_jal_issue", issue, 1);
    tick();
    nop();
    tick();
    ins(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_ctrl_stall", stall, 1);
      tick();
    end
    @(negedge clk);
    chk("t6_br_issue", issue, 1);
    chk("t6_br_stall", stall, 0);
    tick();
    nop();
    repeat (3) tick();

    // Counter saturation under a self-dependent load stream
    ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    repeat (600) tick();
    @(negedge clk);
    chk("sat_cnt", cnt, 8'hFF);
    tick();
    repeat (20) tick();
    @(negedge clk);
    chk("sat_hold", cnt, 8'hFF);
    tick();
    nop();
    repeat (3) tick();

    // Asynchronous reset mid-stream discards in-flight entries
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("mid_w_before", w_wen, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_w_after", w_wen, 0);
    chk("mid_cnt", cnt, 0);
    chk("mid_issue", issue, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
